// File: rtl/player_input_ctrl.sv
// player_input_ctrl: board push-button conditioner for the player sprite.
// Each button is synchronized and debounced. Opposing directions on the same
// axis cancel. The result is latched on the falling edge of move_clock, so the
// sprite logic, which samples on the rising edge, always sees stable levels.
// Optional build macro DIAG_LOCK_EN: allow at most one active direction.
// The axis that is already latched keeps priority; horizontal wins a fresh tie.
module player_input_ctrl #(
  parameter int DEBOUNCE_CNT = 500000,
  parameter int MOVE_DIV     = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_up,
  input  logic btn_down,
  output logic left,
  output logic right,
  output logic up,
  output logic down,
  output logic move_clock,
  output logic move_tick
);

  localparam int CW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam int DW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(MOVE_DIV - 1);

  // bit order everywhere: [3]=left [2]=right [1]=up [0]=down
  logic [3:0]         w_btn;
  logic [3:0]         r_sync1, r_sync2, r_deb;
  logic [3:0][CW-1:0] r_cnt;
  logic [DW-1:0]      r_div;
  logic               r_mclk, r_tick;
  logic               r_left, r_right, r_up, r_down;
  logic               w_div_last, w_latch;
  logic               w_h_l, w_h_r, w_v_u, w_v_d;
  logic [3:0]         w_nxt;

  assign w_btn = {btn_left, btn_right, btn_up, btn_down};

  // two-flop synchronizer for the asynchronous buttons
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
    end
  end

  // per-button debounce: accept a change only after it holds DEBOUNCE_CNT cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb <= '0;
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_div_last = (r_div == DIV_LAST);
  // Latch when move_clock is about to fall. The sprite's rising edge is then
  // half a period away.
  assign w_latch    = w_div_last & r_mclk;

  // move divider: toggle move_clock every MOVE_DIV cycles, tick on its rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_mclk <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_div  <= w_div_last ? '0 : r_div + 1'b1;
      r_tick <= w_div_last & ~r_mclk;
      if (w_div_last) r_mclk <= ~r_mclk;
    end
  end

  // opposing buttons on one axis cancel to no request
  assign w_h_l = r_deb[3] & ~r_deb[2];
  assign w_h_r = r_deb[2] & ~r_deb[3];
  assign w_v_u = r_deb[1] & ~r_deb[0];
  assign w_v_d = r_deb[0] & ~r_deb[1];

  // next latched directions, with optional single-axis lock
  always_comb begin
    w_nxt = {w_h_l, w_h_r, w_v_u, w_v_d};
`ifdef DIAG_LOCK_EN
    if ((w_h_l | w_h_r) && (w_v_u | w_v_d)) begin
      // tie: a vertical axis that is already latched keeps priority
      if (r_up | r_down) w_nxt = {2'b00, w_v_u, w_v_d};
      else               w_nxt = {w_h_l, w_h_r, 2'b00};
    end
`endif
  end

  // direction output latch, loaded only on the move_clock 1->0 cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_left  <= 1'b0;
      r_right <= 1'b0;
      r_up    <= 1'b0;
      r_down  <= 1'b0;
    end else if (w_latch) begin
      r_left  <= w_nxt[3];
      r_right <= w_nxt[2];
      r_up    <= w_nxt[1];
      r_down  <= w_nxt[0];
    end
  end

  assign left       = r_left;
  assign right      = r_right;
  assign up         = r_up;
  assign down       = r_down;
  assign move_clock = r_mclk;
  assign move_tick  = r_tick;

endmodule
